paddle_capture: RTL
===================

# paddle_capture

Digitizes the two analog paddle comparator inputs into per-frame 8-bit positions for the paddle display/game logic. Each paddle input rises at a scanline proportional to the pot setting. The block synchronizes that asynchronous edge into the video clock domain and time-stamps it against the sync generator's `vpos`. It then publishes a stable `paddle_x`/`paddle_y` pair once per frame at the rising edge of `vsync`, so no downstream logic is clocked by a paddle pin.

## Interface

Parameters:
- `MIN_LINE`, default 8: paddle edges while `vpos` < `MIN_LINE` are ignored; this is the capacitor discharge window.
- `SMOOTH`, default 0: 1 selects a two-frame average on the published value; 0 publishes the raw value.

Ports:
- `clk`, in, 1: the single clock, shared with the sync generator. Rising-edge.
- `reset`, in, 1: reset is asynchronous and active-low.
- `hpaddle`, in, 1: asynchronous paddle comparator for the X channel.
- `vpaddle`, in, 1: asynchronous paddle comparator for the Y channel.
- `vpos`, in, 9: current scanline from the sync generator.
- `vsync`, in, 1: active-high vertical sync from the sync generator, synchronous to `clk`.
- `paddle_x`, out, 8: published X position.
- `paddle_y`, out, 8: published Y position.
- `hmiss`, out, 1: set when the last frame had no valid X edge.
- `vmiss`, out, 1: set when the last frame had no valid Y edge.
- `frame_strobe`, out, 1: one-cycle pulse when new values are published.

## Operation

Per channel (X shown; Y is identical):

Input path:
- 2-flop synchronizer followed by a previous-sample register.
- `rise` = synced & ~prev.

Channel states:
- ARMED:
  - `rise` && `vpos` ≥ `MIN_LINE`: `raw_x` <= `vpos` saturated to 8 bits (`vpos` > 255 gives 255), then go to CAPTURED.
  - `rise` with `vpos` < `MIN_LINE`: ignored, stay ARMED.
- CAPTURED: further rises are ignored until frame end.

Frame end is `vs_rise` = `vsync` & ~`vsync_d`. On `vs_rise`, for each channel:
- Captured value:
  - From CAPTURED: captured = `raw_x`, and `hmiss` <= 0.
  - From ARMED (no valid edge): captured = 255, and `hmiss` <= 1.
- Published value:
  - `SMOOTH`=0: `paddle_x` <= captured.
  - `SMOOTH`=1: `paddle_x` <= (captured + `last_x`) >> 1, using a 9-bit sum and truncation. Then `last_x` <= captured.
- The channel returns to ARMED.
- `frame_strobe` <= 1 for exactly one cycle.

Simultaneous events:
- If a valid `rise` and `vs_rise` occur in the same cycle while ARMED, the edge belongs to the closing frame. The `vpos` from that cycle is published and the miss flag is 0.
- The new frame then starts ARMED.

Between strobes, `paddle_x`, `paddle_y`, `hmiss` and `vmiss` hold their values.

## Timing

Reset values:
- `paddle_x` = 0, `paddle_y` = 0, `hmiss` = 0, `vmiss` = 0, `frame_strobe` = 0.
- `raw_*` = 0, `last_*` = 0, both channels ARMED.
- Synchronizer and prev flops = 1, and `vsync_d` = 1. A high input or a high `vsync` at reset release therefore produces no false edge.

Latency:
- A pin rise reaches `rise` on the 3rd clock edge after the pin transition (2 sync + 1 prev).
- `vpos` is sampled in that cycle.
- Lines are hundreds of clocks long, so this introduces at most a one-line error, which is accepted.

Publish timing:
- Outputs update on the clock edge following the cycle in which `vsync` is first seen high.
- `frame_strobe` is high during the cycle after that edge and for one cycle only.

Reset asserted mid-frame:
- All state clears immediately; any partial capture is discarded.
- The first publish after release occurs at the first `vsync` rising edge that follows a `vsync` low sample.

## Test plan

- **Basic capture.** Reset, then `hpaddle` rises at `vpos`=100 and `vpaddle` at `vpos`=37, then `vsync` rises → `paddle_x`=100, `paddle_y`=37, both miss flags 0, `frame_strobe` high for 1 cycle.
- **Miss and saturation.**
  - No `hpaddle` edge in a frame → `paddle_x`=255, `hmiss`=1.
  - `vpaddle` rises at `vpos`=300 → `paddle_y`=255, `vmiss`=0.
- **Deadzone and first-edge-wins.** Rise at `vpos`=3 (ignored), pin drops, rise at 50, drops, rise at 90 → `paddle_x`=50.
- **SMOOTH=1 sequence.** Captures of 100 then 201 over two frames → published 50, then 150.
- **Edge on frame boundary.**
  - `rise` in the same cycle as `vs_rise`, `vpos`=240 → published 240, miss flag 0.
  - Next frame with no edge → 255, miss flag 1.
- **Reset behaviour.**
  - Assert `reset` low mid-frame after a capture → all outputs 0 asynchronously.
  - Release with `vsync` and `hpaddle` high → no strobe until the next `vsync` low-to-high transition.
  - The publish after that strobe shows a miss (255) unless a new edge occurred.

Source files
------------

// File: rtl/paddle_capture.sv
// Paddle digitizer: synchronizes two asynchronous comparator edges, time-stamps
// them against vpos, and publishes one stable X/Y pair per frame on vsync rise.
module paddle_capture #(
    parameter int MIN_LINE = 8,
    parameter int SMOOTH   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hpaddle,
    input  logic       vpaddle,
    input  logic [8:0] vpos,
    input  logic       vsync,
    output logic [7:0] paddle_x,
    output logic [7:0] paddle_y,
    output logic       hmiss,
    output logic       vmiss,
    output logic       frame_strobe
);

    typedef enum logic {
        ARMED    = 1'b0,
        CAPTURED = 1'b1
    } chan_state_t;

    localparam logic [8:0] MIN_LINE_V = 9'(MIN_LINE);

    // Bit 0 is the X channel, bit 1 the Y channel.
    logic [1:0]      sync1, sync2, prev, rise;
    logic            vsync_d, vs_rise;
    logic [7:0]      vpos_sat;
    logic            line_ok;
    logic [1:0][7:0] pub;
    logic [1:0]      miss;

    // Flops reset high so a pin or vsync already high at release is not an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1        <= 2'b11;
            sync2        <= 2'b11;
            prev         <= 2'b11;
            vsync_d      <= 1'b1;
            frame_strobe <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the old value,
            // which is what makes sync1 -> sync2 -> prev a real three-stage chain.
            sync1        <= {vpaddle, hpaddle};
            sync2        <= sync1;
            prev         <= sync2;
            vsync_d      <= vsync;
            frame_strobe <= vs_rise;
        end
    end

    assign rise     = sync2 & ~prev;
    assign vs_rise  = vsync & ~vsync_d;
    assign vpos_sat = vpos[8] ? 8'hFF : vpos[7:0];
    assign line_ok  = (vpos >= MIN_LINE_V);

    for (genvar c = 0; c < 2; c++) begin : g_chan
        chan_state_t state, state_nx;
        logic [7:0]  raw, raw_nx, last, last_nx, pub_q, pub_nx, captured;
        logic        miss_q, miss_nx, take;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state  <= ARMED;
                raw    <= 8'd0;
                last   <= 8'd0;
                pub_q  <= 8'd0;
                miss_q <= 1'b0;
            end else begin
                state  <= state_nx;
                raw    <= raw_nx;
                last   <= last_nx;
                pub_q  <= pub_nx;
                miss_q <= miss_nx;
            end
        end

        always_comb begin
            // NOTE: every output of this block gets a default first, so no path
            // can leave one unassigned and infer a latch.
            state_nx = state;
            raw_nx   = raw;
            last_nx  = last;
            pub_nx   = pub_q;
            miss_nx  = miss_q;
            captured = 8'hFF;
            take     = rise[c] && line_ok && (state == ARMED);

            if (take) begin
                raw_nx   = vpos_sat;
                state_nx = CAPTURED;
            end

            // An edge landing on the frame boundary closes the old frame.
            if (vs_rise) begin
                if (take) begin
                    captured = vpos_sat;
                end else if (state == CAPTURED) begin
                    captured = raw;
                end
                miss_nx  = !(take || (state == CAPTURED));
                pub_nx   = (SMOOTH != 0) ? 8'(({1'b0, captured} + {1'b0, last}) >> 1)
                                         : captured;
                last_nx  = captured;
                state_nx = ARMED;
            end
        end

        assign pub[c]  = pub_q;
        assign miss[c] = miss_q;
    end

    assign paddle_x = pub[0];
    assign paddle_y = pub[1];
    assign hmiss    = miss[0];
    assign vmiss    = miss[1];

endmodule
